timer_controller: RTL and testbench
===================================

# timer_controller

Sequencing controller for the countdown timer datapath. Generates the one-second tick internally from the system clock, edge-detects the start/pause/restart buttons, and owns the 6-bit remaining-seconds register. It also raises an alarm on expiry. It sits between the button inputs and the seven-segment decoder, which consumes `count`, and replaces the divided-clock arrangement with single-clock tick enables.

## Interface
Parameters:
- `TICK_DIV`, default 100_000_000: clock cycles per one-second tick; must be ≥2.
- `MAX_SECONDS`, default 59: largest loadable value; larger `seconds` inputs clamp to it.
- `ALARM_TICKS`, default 5: number of ticks `alarm` stays high after expiry.

Ports:
- `clock`, in, 1: single system clock, rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `seconds`, in, 6: countdown preset, level, synchronous to `clock`.
- `start`, in, 1: start/resume button, level, already debounced and synchronised.
- `pause`, in, 1: pause/resume button, level, already debounced and synchronised.
- `restart`, in, 1: return-to-idle button, level, already debounced and synchronised.
- `count`, out, 6: remaining seconds, 0..MAX_SECONDS.
- `running`, out, 1: high in RUN.
- `paused`, out, 1: high in PAUSE.
- `expired`, out, 1: high in DONE.
- `alarm`, out, 1: high for the first ALARM_TICKS ticks of DONE.
- `tick`, out, 1: one-cycle pulse on each prescaler wrap.

## Operation
- Buttons: rising edge = `in & ~prev`, where `prev` is registered each cycle. `prev` resets to 1, so a button held through reset never fires. Each edge is acted on exactly once.
- Event priority when edges coincide: restart > pause > start.
- States: IDLE, RUN, PAUSE, DONE. Reset state is IDLE.
- IDLE:
  - `count` loads `min(seconds, MAX_SECONDS)` every cycle.
  - start edge with a nonzero load value → RUN.
  - start edge with a zero load value → DONE.
  - pause edge is ignored.
- RUN:
  - On `tick`, if `count`==1: `count`←0 and go to DONE. Otherwise `count`←`count`−1.
  - pause edge → PAUSE.
  - start edge is ignored.
- PAUSE:
  - `count` and the prescaler hold their values.
  - start edge or pause edge → RUN, resuming the prescaler from its held value.
- DONE:
  - `count` holds at 0.
  - Prescaler keeps running. Alarm counter increments on each `tick`, and `alarm`=1 while the alarm counter < ALARM_TICKS.
  - start and pause edges are ignored.
- restart edge in any state → IDLE. Prescaler and alarm counter clear.
- Prescaler:
  - 0..TICK_DIV−1. Increments in RUN and DONE, holds in PAUSE, cleared in IDLE.
  - Also cleared on the IDLE→RUN transition.
  - `tick` = (prescaler == TICK_DIV−1) && state∈{RUN, DONE}. Wraps to 0 on the same edge.
- `count` never underflows. A tick in DONE does not change `count`.

## Timing
- Reset values: state IDLE, `count`=0, prescaler 0, alarm counter 0, `prev`=3'b111.
- Output values in reset: `running`=`paused`=`expired`=`alarm`=`tick`=0.
- `count` shows the clamped preset one cycle after reset is released.
- Button to state change: the state changes at the first rising edge at which the button is sampled high after being sampled low, so latency is 1 clock.
- Start to first tick: the first decrement happens TICK_DIV cycles after the start edge is taken.
- Decrement period: one decrement every TICK_DIV cycles of RUN; time spent in PAUSE is excluded.
- `count` 1→0 and RUN→DONE occur on the same edge. `expired` and `alarm` are high from the next cycle.
- State-flag outputs are decoded from the state register: registered, no combinational path from the buttons.
- `tick` is decoded from the prescaler register and state, with no combinational path from inputs.
- A restart edge coinciding with a tick wins: state goes to IDLE and `count` loads the preset, not the decremented value.

## Structure
- Package `timer_pkg`:
  - state enum `timer_state_t` {IDLE, RUN, PAUSE, DONE}
  - `SEC_W`=6
  - default `MAX_SECONDS`
- Sub-module `edge_detect`: 1-bit rising-edge detector with reset value 1, instantiated three times.
- The FSM, prescaler, count register and alarm counter stay in `timer_controller`.
- Prescaler width is `$clog2(TICK_DIV)`. Alarm counter width is `$clog2(ALARM_TICKS+1)` and saturates at ALARM_TICKS.

## Test plan
(Simulation uses TICK_DIV=4, ALARM_TICKS=2.)
- Basic countdown: `seconds`=3, start pulse → `running`=1 after 1 clock; `count` steps 3→2→1→0 at 4-cycle intervals; `expired`=1; `alarm` high for exactly 8 cycles, then low with `count` still 0.
- Clamp and zero preset:
  - `seconds`=63 in IDLE → `count`=59.
  - `seconds`=0, start → DONE in 1 clock, `alarm` asserted.
- Pause/resume: start with 5, pause 2 cycles after the first tick, wait 20 cycles → `count` stays 4. Resume with start → next decrement 2 cycles later (prescaler held at 2).
- Simultaneous events:
  - restart+pause+start edges in RUN on the same cycle → IDLE.
  - restart on a tick cycle with `count`=2 → `count`=preset, not 1.
- Reset behaviour: `start` held high across `rst_n` release → stays IDLE. Assert `rst_n` mid-RUN → all outputs 0 immediately (asynchronous).
- Held button: start held high for 10 cycles in PAUSE → resumes once. A subsequent pause edge pauses normally.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared types and constants for the countdown timer controller.
package timer_pkg;

  localparam int SEC_W               = 6;
  localparam int DEFAULT_MAX_SECONDS = 59;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } timer_state_t;

  // Preset limited to the largest loadable value.
  function automatic logic [SEC_W-1:0] clamp_seconds(
    input logic [SEC_W-1:0] s,
    input logic [SEC_W-1:0] max_s
  );
    return (s > max_s) ? max_s : s;
  endfunction

endpackage

// File: rtl/timer_controller_edge_detect.sv
// edge_detect: 1-bit rising-edge detector.
//   clock, rst_n : clock, async active-low reset
//   d            : level input
//   rise         : d & ~prev; prev resets to 1 so a level held through reset never fires
module edge_detect (
  input  logic clock,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic prev;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) prev <= 1'b1;
    else        prev <= d;
  end

  assign rise = d & ~prev;

endmodule

// File: rtl/timer_controller.sv
// timer_controller: countdown timer sequencer with internal one-second tick.
//   clock, rst_n          : system clock, async active-low reset
//   seconds               : countdown preset (clamped to MAX_SECONDS)
//   start, pause, restart : debounced button levels
//   count                 : remaining seconds
//   running/paused/expired: state flags (RUN/PAUSE/DONE)
//   alarm                 : high for the first ALARM_TICKS ticks of DONE
//   tick                  : one-cycle pulse on each prescaler wrap
module timer_controller
  import timer_pkg::*;
#(
  parameter int TICK_DIV    = 100_000_000,
  parameter int MAX_SECONDS = DEFAULT_MAX_SECONDS,
  parameter int ALARM_TICKS = 5
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic [SEC_W-1:0] seconds,
  input  logic             start,
  input  logic             pause,
  input  logic             restart,
  output logic [SEC_W-1:0] count,
  output logic             running,
  output logic             paused,
  output logic             expired,
  output logic             alarm,
  output logic             tick
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int AW = $clog2(ALARM_TICKS + 1);

  localparam logic [PW-1:0]    TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [AW-1:0]    ALARM_MAX = AW'(ALARM_TICKS);
  localparam logic [SEC_W-1:0] MAX_V     = SEC_W'(MAX_SECONDS);

  timer_state_t     state;
  logic [PW-1:0]    presc;
  logic [AW-1:0]    alarm_cnt;
  logic [SEC_W-1:0] load_val;
  logic             start_rise;
  logic             pause_rise;
  logic             restart_rise;

  edge_detect u_start_ed (
    .clock (clock),
    .rst_n (rst_n),
    .d     (start),
    .rise  (start_rise)
  );

  edge_detect u_pause_ed (
    .clock (clock),
    .rst_n (rst_n),
    .d     (pause),
    .rise  (pause_rise)
  );

  edge_detect u_restart_ed (
    .clock (clock),
    .rst_n (rst_n),
    .d     (restart),
    .rise  (restart_rise)
  );

  assign load_val = clamp_seconds(seconds, MAX_V);

  assign tick    = (presc == TICK_LAST) && ((state == RUN) || (state == DONE));
  assign running = (state == RUN);
  assign paused  = (state == PAUSE);
  assign expired = (state == DONE);
  assign alarm   = (state == DONE) && (alarm_cnt < ALARM_MAX);

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      count     <= '0;
      presc     <= '0;
      alarm_cnt <= '0;
    end else if (restart_rise) begin
      state     <= IDLE;
      count     <= load_val;
      presc     <= '0;
      alarm_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          count     <= load_val;
          presc     <= '0;
          alarm_cnt <= '0;
          if (start_rise) begin
            state <= (load_val == '0) ? DONE : RUN;
          end
        end

        RUN: begin
          // A tick coinciding with a pause edge is still consumed, so the
          // paused prescaler never sits past its wrap point.
          if (tick) begin
            presc <= '0;
            if (count == SEC_W'(1)) begin
              count <= '0;
              state <= DONE;
            end else begin
              count <= count - 1'b1;
              if (pause_rise) state <= PAUSE;
            end
          end else if (pause_rise) begin
            state <= PAUSE;
          end else begin
            presc <= presc + 1'b1;
          end
        end

        PAUSE: begin
          if (pause_rise || start_rise) state <= RUN;
        end

        DONE: begin
          count <= '0;
          if (tick) begin
            presc <= '0;
            if (alarm_cnt < ALARM_MAX) alarm_cnt <= alarm_cnt + 1'b1;
          end else begin
            presc <= presc + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_timer_controller.sv
module tb_timer_controller;

  logic       clock;
  logic       rst_n;
  logic [5:0] seconds;
  logic       start;
  logic       pause;
  logic       restart;
  logic [5:0] count;
  logic       running;
  logic       paused;
  logic       expired;
  logic       alarm;
  logic       tick;

  int checks;
  int failures;

  typedef struct {
    logic [5:0]  seconds;
    logic        start;
    logic        pause;
    logic        restart;
    logic [10:0] exp;
  } vec_t;

  vec_t vq[$];

  timer_controller #(
    .TICK_DIV    (4),
    .MAX_SECONDS (59),
    .ALARM_TICKS (2)
  ) dut (
    .clock   (clock),
    .rst_n   (rst_n),
    .seconds (seconds),
    .start   (start),
    .pause   (pause),
    .restart (restart),
    .count   (count),
    .running (running),
    .paused  (paused),
    .expired (expired),
    .alarm   (alarm),
    .tick    (tick)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // {count, running, paused, expired, alarm, tick}
  function automatic logic [10:0] pk(input int c, input logic r, input logic p,
                                     input logic e, input logic a, input logic t);
    return {6'(c), r, p, e, a, t};
  endfunction

  task automatic check(input string name, input logic [10:0] exp);
    logic [10:0] act;
    act = {count, running, paused, expired, alarm, tick};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got count=%0d flags(r,p,e,a,t)=%05b, expected count=%0d flags=%05b",
               name, act[10:5], act[4:0], exp[10:5], exp[4:0]);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [5:0] s, input logic st, input logic pa, input logic re);
    seconds = s;
    start   = st;
    pause   = pa;
    restart = re;
  endtask

  task automatic add(input int s, input logic st, input logic pa, input logic re,
                     input logic [10:0] exp);
    vec_t v;
    v.seconds = 6'(s);
    v.start   = st;
    v.pause   = pa;
    v.restart = re;
    v.exp     = exp;
    vq.push_back(v);
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    // Basic countdown from 3, alarm window, clamp, zero preset.
    add(3, 0, 0, 0, pk(3, 0, 0, 0, 0, 0));   // preset visible after reset release
    add(3, 1, 0, 0, pk(3, 1, 0, 0, 0, 0));   // start edge -> RUN
    add(3, 0, 0, 0, pk(3, 1, 0, 0, 0, 0));
    add(3, 0, 0, 0, pk(3, 1, 0, 0, 0, 0));
    add(3, 0, 0, 0, pk(3, 1, 0, 0, 0, 1));
    add(3, 0, 0, 0, pk(2, 1, 0, 0, 0, 0));
    add(3, 0, 0, 0, pk(2, 1, 0, 0, 0, 0));
    add(3, 0, 0, 0, pk(2, 1, 0, 0, 0, 0));
    add(3, 0, 0, 0, pk(2, 1, 0, 0, 0, 1));
    add(3, 0, 0, 0, pk(1, 1, 0, 0, 0, 0));
    add(3, 0, 0, 0, pk(1, 1, 0, 0, 0, 0));
    add(3, 0, 0, 0, pk(1, 1, 0, 0, 0, 0));
    add(3, 0, 0, 0, pk(1, 1, 0, 0, 0, 1));
    add(3, 0, 0, 0, pk(0, 0, 0, 1, 1, 0));   // expiry
    add(3, 0, 0, 0, pk(0, 0, 0, 1, 1, 0));
    add(3, 0, 0, 0, pk(0, 0, 0, 1, 1, 0));
    add(3, 0, 0, 0, pk(0, 0, 0, 1, 1, 1));
    add(3, 0, 0, 0, pk(0, 0, 0, 1, 1, 0));
    add(3, 0, 0, 0, pk(0, 0, 0, 1, 1, 0));
    add(3, 0, 0, 0, pk(0, 0, 0, 1, 1, 0));
    add(3, 0, 0, 0, pk(0, 0, 0, 1, 1, 1));
    add(3, 0, 0, 0, pk(0, 0, 0, 1, 0, 0));   // alarm ends after 8 cycles
    add(3, 1, 0, 0, pk(0, 0, 0, 1, 0, 0));   // start ignored in DONE
    add(3, 0, 0, 1, pk(3, 0, 0, 0, 0, 0));   // restart -> IDLE
    add(63, 0, 0, 0, pk(59, 0, 0, 0, 0, 0)); // clamp
    add(0, 1, 0, 0, pk(0, 0, 0, 1, 1, 0));   // zero preset -> DONE
    add(0, 0, 0, 1, pk(0, 0, 0, 0, 0, 0));

    rst_n = 1'b0;
    drive(6'd3, 1'b0, 1'b0, 1'b0);
    #1;
    check("reset_state", pk(0, 0, 0, 0, 0, 0));
    #22 rst_n = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].seconds, vq[i].start, vq[i].pause, vq[i].restart);
      cyc();
      check($sformatf("vec%0d", i), vq[i].exp);
    end

    // Pause / resume with held start.
    drive(6'd5, 1'b0, 1'b0, 1'b0); cyc();
    check("pr_idle", pk(5, 0, 0, 0, 0, 0));
    start = 1'b1; cyc();
    check("pr_start", pk(5, 1, 0, 0, 0, 0));
    start = 1'b0; cyc(); cyc(); cyc();
    check("pr_tick1", pk(5, 1, 0, 0, 0, 1));
    cyc();
    check("pr_dec1", pk(4, 1, 0, 0, 0, 0));
    cyc(); cyc();
    pause = 1'b1; cyc();
    check("pr_pause", pk(4, 0, 1, 0, 0, 0));
    pause = 1'b0;
    repeat (20) cyc();
    check("pr_hold", pk(4, 0, 1, 0, 0, 0));
    start = 1'b1; cyc();
    check("pr_resume", pk(4, 1, 0, 0, 0, 0));
    cyc();
    check("pr_tick2", pk(4, 1, 0, 0, 0, 1));
    cyc();
    check("pr_dec2", pk(3, 1, 0, 0, 0, 0));
    repeat (7) cyc();
    check("held_start", pk(2, 1, 0, 0, 0, 1));
    start = 1'b0; cyc();
    check("held_dec", pk(1, 1, 0, 0, 0, 0));
    pause = 1'b1; cyc();
    check("held_pause", pk(1, 0, 1, 0, 0, 0));

    // Simultaneous restart+pause+start in RUN.
    drive(6'd7, 1'b0, 1'b0, 1'b1); cyc();
    check("sim_idle", pk(7, 0, 0, 0, 0, 0));
    restart = 1'b0; cyc();
    start = 1'b1; cyc();
    check("sim_run", pk(7, 1, 0, 0, 0, 0));
    start = 1'b0; cyc();
    drive(6'd7, 1'b1, 1'b1, 1'b1); cyc();
    check("sim_all", pk(7, 0, 0, 0, 0, 0));

    // Restart on a tick cycle with count=2.
    drive(6'd2, 1'b0, 1'b0, 1'b0); cyc();
    start = 1'b1; cyc();
    start = 1'b0; cyc(); cyc(); cyc();
    check("rt_tick", pk(2, 1, 0, 0, 0, 1));
    restart = 1'b1; cyc();
    check("rt_restart", pk(2, 0, 0, 0, 0, 0));
    restart = 1'b0;

    // Asynchronous reset mid-RUN, start held across release.
    seconds = 6'd9; cyc();
    start = 1'b1; cyc();
    start = 1'b0; cyc(); cyc();
    check("ar_run", pk(9, 1, 0, 0, 0, 0));
    #2 rst_n = 1'b0;
    #1;
    check("async_rst", pk(0, 0, 0, 0, 0, 0));
    start = 1'b1;
    #20 rst_n = 1'b1;
    cyc();
    check("held_rst1", pk(9, 0, 0, 0, 0, 0));
    cyc();
    check("held_rst2", pk(9, 0, 0, 0, 0, 0));
    start = 1'b0; cyc();
    start = 1'b1; cyc();
    check("start_after_rst", pk(9, 1, 0, 0, 0, 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
